pq_sorted: RTL and testbench

- Parametrised successor of the team's single-port `pq`: a sorted shift-register priority queue with configurable depth, data width and ordering mode.
- Adds:
  - ID allocation/recycling
  - same-cycle push+pop
  - drop-by-ID with hit reporting
  - synchronous flush
  - selectable overflow policy (reject or evict-worst)
- Sits between task producers and the scheduler; the head entry is always visible on the peek port.

---
 rtl/pq_pkg.sv | 29 ++
 rtl/pq_id_alloc.sv | 62 ++++++
 rtl/pq_sorted.sv | 186 ++++++++++++++++++
 tb/tb_pq_sorted.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pq_pkg
//  Brief    : Shared widths, entry type and key-ordering helper for pq_sorted.
//  Revision : 1.0
// ============================================================================
package pq_pkg;

    localparam int QUEUE_DEPTH = 8;
    localparam int DATA_WIDTH  = 8;
    localparam int ID_WIDTH    = $clog2(QUEUE_DEPTH);
    localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH + 1);
    // Keys are zero-extended to this width before comparison.
    localparam int KEY_MAX_W   = 64;

    typedef struct packed {
        logic                  vld;
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } pq_entry_t;

    function automatic logic pq_better(input logic [KEY_MAX_W-1:0] a,
                                       input logic [KEY_MAX_W-1:0] b,
                                       input logic                 max_first);
        return max_first ? (a > b) : (a < b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pq_id_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : pq_id_alloc
//  Brief    : Free-ID bitmap with lowest-free encoder; freed IDs reusable same cycle.
//  Revision : 1.0
// ============================================================================
module pq_id_alloc #(
    parameter int DEPTH = 8,
    parameter int IDW   = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           i_flush,
    input  logic           i_alloc,
    input  logic           i_free0,
    input  logic [IDW-1:0] i_free0_id,
    input  logic           i_free1,
    input  logic [IDW-1:0] i_free1_id,
    output logic [IDW-1:0] o_alloc_id
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_freed;
    logic [DEPTH-1:0] w_avail;
    logic [DEPTH-1:0] w_take;
    logic [DEPTH-1:0] w_busy_nxt;

    always_comb begin
        w_freed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i_free0 && i_free0_id == IDW'(i)) || (i_free1 && i_free1_id == IDW'(i)))
                w_freed[i] = 1'b1;
        end
    end

    assign w_avail = ~r_busy | w_freed;

    always_comb begin
        o_alloc_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_avail[i])
                o_alloc_id = IDW'(i);
        end
    end

    always_comb begin
        w_take = '0;
        for (int i = 0; i < DEPTH; i++)
            w_take[i] = i_alloc && (o_alloc_id == IDW'(i));
    end

    assign w_busy_nxt = i_flush ? '0 : ((r_busy & ~w_freed) | w_take);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

endmodule
`default_nettype wire

// File: rtl/pq_sorted.sv
`default_nettype none
// ============================================================================
//  Module   : pq_sorted
//  Brief    : Sorted shift-register priority queue with IDs, drop, flush, overflow policy.
//  Revision : 1.0
// ============================================================================
module pq_sorted
    import pq_pkg::*;
#(
    parameter  int DEPTH     = QUEUE_DEPTH,
    parameter  int DW        = DATA_WIDTH,
    parameter  int MAX_FIRST = 0,
    parameter  int OVF_EVICT = 0,
    localparam int IDW       = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic [DW-1:0]  data_i,
    output logic           push_rdy_o,
    output logic [IDW-1:0] push_id_o,
    input  logic           pop_i,
    output logic           pop_rdy_o,
    output logic [DW-1:0]  data_o,
    output logic [IDW-1:0] pop_id_o,
    input  logic           drop_i,
    input  logic [IDW-1:0] drop_id_i,
    output logic           drop_rdy_o,
    output logic           drop_hit_o,
    input  logic           flush_i,
    output logic           peek_vld_o,
    output logic [DW-1:0]  peek_data_o,
    output logic [IDW-1:0] peek_id_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [CW-1:0]  cnt_o,
    output logic           overflow_o,
    output logic [DW-1:0]  data_overflow_o
);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } slot_t;

    slot_t          r_slot [DEPTH];
    slot_t          w_rem  [DEPTH];
    slot_t          w_nxt  [DEPTH];
    slot_t          w_new;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [IDW-1:0] w_alloc_id;
    logic           w_full, w_empty, w_push_rdy;
    logic           w_pop_ok, w_push_ok, w_drop_rdy, w_full_nopop, w_tail_beat;
    logic           w_evict, w_lost, w_ins, w_hit, w_drop_hit, w_removed;
    int             w_hit_idx, w_rm_idx, w_ins_idx;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);

    generate
        if (OVF_EVICT != 0) begin : g_ovf_evict
            assign w_push_rdy = !flush_i;
        end else begin : g_ovf_reject
            assign w_push_rdy = !flush_i && (!w_full || pop_i);
        end
    endgenerate

    assign w_pop_ok     = pop_i && !flush_i && !w_empty;
    assign w_push_ok    = push_i && w_push_rdy;
    assign w_drop_rdy   = !flush_i && !push_i && !pop_i;
    assign w_full_nopop = w_full && !w_pop_ok;
    assign w_tail_beat  = pq_better(KEY_MAX_W'(data_i), KEY_MAX_W'(r_slot[DEPTH-1].data),
                                    MAX_FIRST != 0);
    // Full with no pop: either the tail is displaced or the incoming entry is.
    assign w_evict      = w_push_ok && w_full_nopop && w_tail_beat;
    assign w_lost       = w_push_ok && w_full_nopop && !w_tail_beat;
    assign w_ins        = w_push_ok && !w_lost;
    assign w_drop_hit   = drop_i && w_drop_rdy && w_hit;
    assign w_removed    = w_pop_ok || w_evict || w_drop_hit;
    assign w_new        = '{vld: 1'b1, id: w_alloc_id, data: data_i};

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_slot[i].vld && r_slot[i].id == drop_id_i) begin
                w_hit     = 1'b1;
                w_hit_idx = i;
            end
        end
    end

    always_comb begin
        w_rm_idx = DEPTH;
        if (w_pop_ok)
            w_rm_idx = 0;
        else if (w_evict)
            w_rm_idx = DEPTH - 1;
        else if (w_drop_hit)
            w_rm_idx = w_hit_idx;
    end

    // Close the gap left by the removed slot, then open one for the insert.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++)
            w_rem[i] = (i < w_rm_idx) ? r_slot[i] : r_slot[i+1];
        w_rem[DEPTH-1] = (w_rm_idx <= DEPTH - 1) ? '0 : r_slot[DEPTH-1];
    end

    always_comb begin
        w_ins_idx = DEPTH;
        if (w_ins) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!w_rem[i].vld ||
                    pq_better(KEY_MAX_W'(data_i), KEY_MAX_W'(w_rem[i].data), MAX_FIRST != 0))
                    w_ins_idx = i;
            end
        end
    end

    always_comb begin
        w_nxt[0] = (w_ins_idx == 0) ? w_new : w_rem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (i < w_ins_idx)
                w_nxt[i] = w_rem[i];
            else if (i == w_ins_idx)
                w_nxt[i] = w_new;
            else
                w_nxt[i] = w_rem[i-1];
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++)
                w_nxt[i] = '0;
        end
    end

    assign w_cnt_nxt = flush_i ? '0 : (r_cnt + CW'(w_ins) - CW'(w_removed));

    pq_id_alloc #(
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) u_id_alloc (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_flush    (flush_i),
        .i_alloc    (w_ins),
        .i_free0    (w_pop_ok || w_evict),
        .i_free0_id (w_pop_ok ? r_slot[0].id : r_slot[DEPTH-1].id),
        .i_free1    (w_drop_hit),
        .i_free1_id (drop_id_i),
        .o_alloc_id (w_alloc_id)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++)
                r_slot[i] <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                r_slot[i] <= w_nxt[i];
            r_cnt <= w_cnt_nxt;
        end
    end

    assign push_rdy_o      = w_push_rdy;
    assign push_id_o       = w_ins ? w_alloc_id : '0;
    assign pop_rdy_o       = !flush_i && !w_empty;
    assign data_o          = r_slot[0].data;
    assign pop_id_o        = r_slot[0].id;
    assign drop_rdy_o      = w_drop_rdy;
    assign drop_hit_o      = w_drop_hit;
    assign peek_vld_o      = r_slot[0].vld;
    assign peek_data_o     = r_slot[0].data;
    assign peek_id_o       = r_slot[0].id;
    assign full_o          = w_full;
    assign empty_o         = w_empty;
    assign cnt_o           = r_cnt;
    assign overflow_o      = w_evict || w_lost;
    assign data_overflow_o = w_evict ? r_slot[DEPTH-1].data : (w_lost ? data_i : '0);

endmodule
`default_nettype wire

// File: tb/tb_pq_sorted.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pq_sorted
//  Brief    : Directed bench for pq_sorted in min, max and evict configurations.
//  Revision : 1.0
// ============================================================================
module tb_pq_sorted;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push, pop, drop, flush;
    logic [7:0] din;
    logic [2:0] drop_id;

    logic       a_push_rdy, a_pop_rdy, a_drop_rdy, a_drop_hit, a_peek_vld, a_full, a_empty, a_ovf;
    logic [2:0] a_push_id, a_pop_id, a_peek_id;
    logic [7:0] a_data, a_peek_data, a_ovf_data;
    logic [3:0] a_cnt;

    logic       b_push_rdy, b_pop_rdy, b_drop_rdy, b_drop_hit, b_peek_vld, b_full, b_empty, b_ovf;
    logic [2:0] b_push_id, b_pop_id, b_peek_id;
    logic [7:0] b_data, b_peek_data, b_ovf_data;
    logic [3:0] b_cnt;

    logic       c_push_rdy, c_pop_rdy, c_drop_rdy, c_drop_hit, c_peek_vld, c_full, c_empty, c_ovf;
    logic [1:0] c_push_id, c_pop_id, c_peek_id;
    logic [7:0] c_data, c_peek_data, c_ovf_data;
    logic [2:0] c_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pq_sorted #(.DEPTH(8), .DW(8), .MAX_FIRST(0), .OVF_EVICT(0)) u_min (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .data_i(din), .push_rdy_o(a_push_rdy),
        .push_id_o(a_push_id), .pop_i(pop), .pop_rdy_o(a_pop_rdy), .data_o(a_data),
        .pop_id_o(a_pop_id), .drop_i(drop), .drop_id_i(drop_id), .drop_rdy_o(a_drop_rdy),
        .drop_hit_o(a_drop_hit), .flush_i(flush), .peek_vld_o(a_peek_vld),
        .peek_data_o(a_peek_data), .peek_id_o(a_peek_id), .full_o(a_full), .empty_o(a_empty),
        .cnt_o(a_cnt), .overflow_o(a_ovf), .data_overflow_o(a_ovf_data));

    pq_sorted #(.DEPTH(8), .DW(8), .MAX_FIRST(1), .OVF_EVICT(0)) u_max (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .data_i(din), .push_rdy_o(b_push_rdy),
        .push_id_o(b_push_id), .pop_i(pop), .pop_rdy_o(b_pop_rdy), .data_o(b_data),
        .pop_id_o(b_pop_id), .drop_i(drop), .drop_id_i(drop_id), .drop_rdy_o(b_drop_rdy),
        .drop_hit_o(b_drop_hit), .flush_i(flush), .peek_vld_o(b_peek_vld),
        .peek_data_o(b_peek_data), .peek_id_o(b_peek_id), .full_o(b_full), .empty_o(b_empty),
        .cnt_o(b_cnt), .overflow_o(b_ovf), .data_overflow_o(b_ovf_data));

    pq_sorted #(.DEPTH(4), .DW(8), .MAX_FIRST(0), .OVF_EVICT(1)) u_evt (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .data_i(din), .push_rdy_o(c_push_rdy),
        .push_id_o(c_push_id), .pop_i(pop), .pop_rdy_o(c_pop_rdy), .data_o(c_data),
        .pop_id_o(c_pop_id), .drop_i(drop), .drop_id_i(drop_id[1:0]), .drop_rdy_o(c_drop_rdy),
        .drop_hit_o(c_drop_hit), .flush_i(flush), .peek_vld_o(c_peek_vld),
        .peek_data_o(c_peek_data), .peek_id_o(c_peek_id), .full_o(c_full), .empty_o(c_empty),
        .cnt_o(c_cnt), .overflow_o(c_ovf), .data_overflow_o(c_ovf_data));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [7:0] d, input logic q,
                         input logic dr, input logic [2:0] di, input logic f);
        push = p; din = d; pop = q; drop = dr; drop_id = di; flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_tick(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_d [4];
        logic [1:0] exp_i [4];
        exp_d = '{8'h02, 8'h03, 8'h04, 8'h06};
        exp_i = '{2'd0, 2'd3, 2'd1, 2'd2};

        rst_n = 1'b0;
        push = 1'b0; din = '0; pop = 1'b0; drop = 1'b0; drop_id = '0; flush = 1'b0;
        #2;
        check_eq("rst_cnt",      32'(a_cnt),       0);
        check_eq("rst_empty",    32'(a_empty),     1);
        check_eq("rst_full",     32'(a_full),      0);
        check_eq("rst_peek_vld", 32'(a_peek_vld),  0);
        check_eq("rst_data",     32'(a_data),      0);
        check_eq("rst_ovf",      32'(c_ovf),       0);
        check_eq("rst_pop_rdy",  32'(a_pop_rdy),   0);
        #1 rst_n = 1'b1;
        tick();

        // Basic min ordering
        drive(1'b1, 8'hF0, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("basic_id0", 32'(a_push_id), 0);
        tick();
        drive(1'b1, 8'h15, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("basic_id1", 32'(a_push_id), 1);
        tick();
        drive(1'b1, 8'h87, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("basic_id2", 32'(a_push_id), 2);
        tick();
        idle();
        check_eq("basic_cnt",  32'(a_cnt),       3);
        check_eq("basic_peek", 32'(a_peek_data), 32'h15);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        check_eq("basic_pop0", 32'(a_data), 32'h15);
        tick();
        check_eq("basic_pop1", 32'(a_data), 32'h87);
        tick();
        check_eq("basic_pop2", 32'(a_data), 32'hF0);
        tick();
        idle();
        check_eq("basic_empty",    32'(a_empty),    1);
        check_eq("basic_peek_vld", 32'(a_peek_vld), 0);

        // Max mode with FIFO tie
        pulse_reset();
        push_tick(8'h10);
        push_tick(8'h40);
        push_tick(8'h10);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        check_eq("max_pop0_d",  32'(b_data),   32'h40);
        check_eq("max_pop0_id", 32'(b_pop_id), 1);
        tick();
        check_eq("max_pop1_d",  32'(b_data),   32'h10);
        check_eq("max_pop1_id", 32'(b_pop_id), 0);
        tick();
        check_eq("max_pop2_d",  32'(b_data),   32'h10);
        check_eq("max_pop2_id", 32'(b_pop_id), 2);
        tick();
        idle();
        check_eq("max_empty", 32'(b_empty), 1);

        // Drop by ID
        pulse_reset();
        push_tick(8'h01);
        push_tick(8'hEB);
        push_tick(8'hAF);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        check_eq("drop_pop", 32'(a_data), 32'h01);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0);
        check_eq("drop_rdy", 32'(a_drop_rdy), 1);
        check_eq("drop_hit", 32'(a_drop_hit), 1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0);
        check_eq("drop_peek", 32'(a_peek_data), 32'hEB);
        check_eq("drop_cnt",  32'(a_cnt),       1);
        check_eq("drop_miss", 32'(a_drop_hit),  0);
        tick();
        idle();
        check_eq("drop_miss_cnt",  32'(a_cnt),       1);
        check_eq("drop_miss_peek", 32'(a_peek_id),   1);

        // Push and pop in the same cycle
        pulse_reset();
        push_tick(8'h01);
        push_tick(8'h11);
        push_tick(8'h12);
        drive(1'b1, 8'h13, 1'b1, 1'b0, 3'd0, 1'b0);
        check_eq("pp_data",    32'(a_data),     32'h01);
        check_eq("pp_push_id", 32'(a_push_id),  0);
        check_eq("pp_drop_rdy",32'(a_drop_rdy), 0);
        tick();
        idle();
        check_eq("pp_cnt",  32'(a_cnt),       3);
        check_eq("pp_peek", 32'(a_peek_data), 32'h11);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        check_eq("pp_last_d",  32'(a_data),   32'h13);
        check_eq("pp_last_id", 32'(a_pop_id), 0);
        tick();

        // Overflow with eviction (DEPTH=4)
        pulse_reset();
        push_tick(8'h02);
        push_tick(8'h04);
        push_tick(8'h06);
        push_tick(8'h08);
        idle();
        check_eq("ev_full", 32'(c_full), 1);
        drive(1'b1, 8'h03, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("ev_ovf",      32'(c_ovf),      1);
        check_eq("ev_ovf_data", 32'(c_ovf_data), 32'h08);
        check_eq("ev_push_id",  32'(c_push_id),  3);
        tick();
        drive(1'b1, 8'h09, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("ev_cnt",       32'(c_cnt),      4);
        check_eq("lost_ovf",     32'(c_ovf),      1);
        check_eq("lost_data",    32'(c_ovf_data), 32'h09);
        check_eq("lost_push_id", 32'(c_push_id),  0);
        tick();
        idle();
        check_eq("ev_ovf_idle", 32'(c_ovf), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
            check_eq($sformatf("ev_pop%0d_d", i),  32'(c_data),   32'(exp_d[i]));
            check_eq($sformatf("ev_pop%0d_id", i), 32'(c_pop_id), 32'(exp_i[i]));
            tick();
        end
        idle();
        check_eq("ev_empty", 32'(c_empty), 1);

        // Reject when full, then flush
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(32'h20 + i), 1'b0, 1'b0, 3'd0, 1'b0);
            check_eq($sformatf("fill_id%0d", i), 32'(a_push_id), 32'(i));
            tick();
        end
        idle();
        check_eq("fill_full", 32'(a_full), 1);
        check_eq("fill_cnt",  32'(a_cnt),  8);
        drive(1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("rej_push_rdy", 32'(a_push_rdy), 0);
        tick();
        drive(1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1);
        check_eq("rej_cnt",       32'(a_cnt),       8);
        check_eq("rej_peek",      32'(a_peek_data), 32'h20);
        check_eq("fl_push_rdy",   32'(a_push_rdy),  0);
        check_eq("fl_pop_rdy",    32'(a_pop_rdy),   0);
        check_eq("fl_drop_rdy",   32'(a_drop_rdy),  0);
        check_eq("fl_evt_rdy",    32'(c_push_rdy),  0);
        tick();
        drive(1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 1'b0);
        check_eq("fl_cnt",     32'(a_cnt),     0);
        check_eq("fl_empty",   32'(a_empty),   1);
        check_eq("fl_push_id", 32'(a_push_id), 0);
        tick();

        // Asynchronous reset during a pop
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        check_eq("ar_pop_rdy", 32'(a_pop_rdy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_cnt",      32'(a_cnt),      0);
        check_eq("ar_empty",    32'(a_empty),    1);
        check_eq("ar_peek_vld", 32'(a_peek_vld), 0);
        check_eq("ar_data",     32'(a_data),     0);
        check_eq("ar_pop_rdy0", 32'(a_pop_rdy),  0);
        pop = 1'b0;
        #1 rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
